// File: rtl/powlib_busarb_if.sv
// Bus bundle between B_RQS requesters, the arbiter and the single downstream write port.
// The arbiter uses the slave view; the environment driving requesters and wrrdy uses master.
interface powlib_busarb_if #(
  parameter int B_RQS = 3,
  parameter int B_AW  = 32,
  parameter int B_DW  = 40
);
  logic [B_AW*B_RQS-1:0] rqaddrs;
  logic [B_DW*B_RQS-1:0] rqdatas;
  logic [B_RQS-1:0]      rqlasts;
  logic [B_RQS-1:0]      rqvlds;
  logic [B_RQS-1:0]      rqrdys;
  logic [B_AW-1:0]       wraddr;
  logic [B_DW-1:0]       wrdata;
  logic                  wrvld;
  logic                  wrrdy;
  logic [B_RQS-1:0]      grants;

  modport slave (
    input  rqaddrs, rqdatas, rqlasts, rqvlds, wrrdy,
    output rqrdys, wraddr, wrdata, wrvld, grants
  );

  modport master (
    output rqaddrs, rqdatas, rqlasts, rqvlds, wrrdy,
    input  rqrdys, wraddr, wrdata, wrvld, grants
  );
endinterface

// File: rtl/powlib_busarb.sv
// Packet-level round-robin arbiter merging B_RQS powlib write requesters onto one registered port.
// Handshake: a beat moves on the rising clk edge when vld and rdy are both high; senders hold addr/data/last while vld && !rdy.
module powlib_busarb #(
  parameter int B_RQS     = 3,
  parameter int B_AW      = 32,
  parameter int B_DW      = 40,
  parameter int MAX_BEATS = 8,
  parameter int IDLE_MAX  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  powlib_busarb_if.slave             bus,
  output logic                       dbg_state_o,
  output logic [$clog2(B_RQS)-1:0]   dbg_ptr_o
);
  localparam int PW = $clog2(B_RQS);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int IW = $clog2(IDLE_MAX + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   gidx_q;
  logic [BW-1:0]   bcnt_q;
  logic [IW-1:0]   icnt_q;
  logic [B_RQS-1:0] grants_q;
  logic [B_AW-1:0] wraddr_q;
  logic [B_DW-1:0] wrdata_q;
  logic            wrvld_q;

  logic            accept;
  logic            xfer;
  logic            g_vld;
  logic            g_last;
  logic [B_AW-1:0] g_addr;
  logic [B_DW-1:0] g_data;
  logic            sel_found;
  logic [PW-1:0]   sel_idx;
  logic [PW:0]     cand;
  logic [PW-1:0]   next_ptr;

  assign accept = ~wrvld_q | bus.wrrdy;

  always_comb begin
    g_vld  = 1'b0;
    g_last = 1'b0;
    g_addr = '0;
    g_data = '0;
    for (int i = 0; i < B_RQS; i++) begin
      if (gidx_q == PW'(i)) begin
        g_vld  = bus.rqvlds[i];
        g_last = bus.rqlasts[i];
        g_addr = bus.rqaddrs[B_AW*i +: B_AW];
        g_data = bus.rqdatas[B_DW*i +: B_DW];
      end
    end
  end

  // First requesting index at or after ptr, wrapping modulo B_RQS.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < B_RQS; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(B_RQS)) cand = cand - (PW+1)'(B_RQS);
      if (!sel_found && bus.rqvlds[cand[PW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PW-1:0];
      end
    end
  end

  assign next_ptr   = (gidx_q == PW'(B_RQS - 1)) ? '0 : gidx_q + PW'(1);
  assign xfer       = (state_q == GRANT) & g_vld & accept;
  assign bus.rqrdys = (state_q == GRANT) ? (grants_q & {B_RQS{accept}}) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      bcnt_q   <= '0;
      icnt_q   <= '0;
      grants_q <= '0;
      wraddr_q <= '0;
      wrdata_q <= '0;
      wrvld_q  <= 1'b0;
    end else begin
      // Output register drains whenever downstream is ready, independent of the FSM.
      if (xfer) begin
        wraddr_q <= g_addr;
        wrdata_q <= g_data;
        wrvld_q  <= 1'b1;
      end else if (bus.wrrdy) begin
        wrvld_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (sel_found) begin
            state_q  <= GRANT;
            grants_q <= B_RQS'(1) << sel_idx;
            gidx_q   <= sel_idx;
            bcnt_q   <= '0;
            icnt_q   <= '0;
          end
        end
        GRANT: begin
          if (xfer) begin
            bcnt_q <= bcnt_q + BW'(1);
            icnt_q <= '0;
            if (g_last || bcnt_q == BW'(MAX_BEATS - 1)) begin
              state_q  <= IDLE;
              grants_q <= '0;
              ptr_q    <= next_ptr;
            end
          end else if (!g_vld) begin
            // Backpressure with vld high leaves icnt untouched, so only true silence times out.
            if (icnt_q == IW'(IDLE_MAX - 1)) begin
              state_q  <= IDLE;
              grants_q <= '0;
              ptr_q    <= next_ptr;
            end else begin
              icnt_q <= icnt_q + IW'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.grants  = grants_q;
  assign bus.wraddr  = wraddr_q;
  assign bus.wrdata  = wrdata_q;
  assign bus.wrvld   = wrvld_q;
  assign dbg_state_o = (state_q == GRANT);
  assign dbg_ptr_o   = ptr_q;
endmodule

// File: tb/tb_powlib_busarb.sv
// Directed bench for powlib_busarb: per-requester source queues, output scoreboard, grant timing tables.
module tb_powlib_busarb;
  localparam int B_RQS     = 3;
  localparam int B_AW      = 32;
  localparam int B_DW      = 40;
  localparam int MAX_BEATS = 8;
  localparam int IDLE_MAX  = 16;
  localparam int EW        = B_AW + B_DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  powlib_busarb_if #(.B_RQS(B_RQS), .B_AW(B_AW), .B_DW(B_DW)) bus ();
  logic       dbg_state;
  logic [1:0] dbg_ptr;

  powlib_busarb #(
    .B_RQS(B_RQS), .B_AW(B_AW), .B_DW(B_DW), .MAX_BEATS(MAX_BEATS), .IDLE_MAX(IDLE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state_o(dbg_state),
    .dbg_ptr_o(dbg_ptr)
  );

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW:0]   src_q[B_RQS][$];

  task automatic check(string tag, logic [EW-1:0] got, logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [B_AW-1:0] beat_addr(int r, int n);
    return 32'h5001_0000 + B_AW'(r * 256) + B_AW'(n * 4);
  endfunction

  function automatic logic [B_DW-1:0] beat_data(int r, int n);
    logic [B_AW-1:0] a;
    a = beat_addr(r, n);
    return {8'(r + 1), ~a};
  endfunction

  // driver tasks
  task automatic push_pkt(int r, int first, int nbeats, bit with_last);
    for (int n = first; n < first + nbeats; n++) begin
      logic lst;
      lst = with_last && (n == first + nbeats - 1);
      src_q[r].push_back({lst, beat_addr(r, n), beat_data(r, n)});
    end
  endtask

  task automatic expect_pkt(int r, int first, int nbeats);
    for (int n = first; n < first + nbeats; n++)
      exp_q.push_back({beat_addr(r, n), beat_data(r, n)});
  endtask

  task automatic drive();
    for (int i = 0; i < B_RQS; i++) begin
      if (src_q[i].size() != 0) begin
        logic [EW:0] b;
        b = src_q[i][0];
        bus.rqvlds[i]                  = 1'b1;
        bus.rqlasts[i]                 = b[EW];
        bus.rqaddrs[B_AW*i +: B_AW]    = b[EW-1:B_DW];
        bus.rqdatas[B_DW*i +: B_DW]    = b[B_DW-1:0];
      end else begin
        bus.rqvlds[i]  = 1'b0;
        bus.rqlasts[i] = 1'b0;
      end
    end
    #1;
  endtask

  // One clock: capture handshakes before the edge, then score and advance sources after it.
  task automatic tick();
    logic [B_RQS-1:0] rq_fire;
    logic             out_fire;
    logic [EW-1:0]    got;
    rq_fire  = bus.rqvlds & bus.rqrdys;
    out_fire = bus.wrvld & bus.wrrdy;
    got      = {bus.wraddr, bus.wrdata};
    @(posedge clk);
    @(negedge clk);
    if (out_fire) begin
      check("sb_pending", EW'(exp_q.size() != 0), EW'(1));
      if (exp_q.size() != 0) check("sb_beat", got, exp_q.pop_front());
    end
    for (int i = 0; i < B_RQS; i++)
      if (rq_fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic run_until_idle(string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      tick();
      done = (exp_q.size() == 0) && !dbg_state && !bus.wrvld;
      for (int i = 0; i < B_RQS; i++) if (src_q[i].size() != 0) done = 1'b0;
    end
    check(tag, EW'(done), EW'(1));
  endtask

  task automatic apply_reset(string tag);
    rst = 1'b0;
    #1;
    check({tag, "_wrvld"},  EW'(bus.wrvld),  EW'(0));
    check({tag, "_grants"}, EW'(bus.grants), EW'(0));
    check({tag, "_rqrdys"}, EW'(bus.rqrdys), EW'(0));
    check({tag, "_wrword"}, {bus.wraddr, bus.wrdata}, EW'(0));
    check({tag, "_ptr"},    EW'(dbg_ptr),    EW'(0));
    check({tag, "_state"},  EW'(dbg_state),  EW'(0));
    for (int i = 0; i < B_RQS; i++) src_q[i].delete();
    exp_q.delete();
    drive();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] t2_g [9];
    logic [2:0] t3_g [13];
    t2_g = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000};
    t3_g = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010,
             3'b000, 3'b100, 3'b100, 3'b000, 3'b010};

    bus.rqaddrs = '0;
    bus.rqdatas = '0;
    bus.rqlasts = '0;
    bus.rqvlds  = '0;
    bus.wrrdy   = 1'b1;
    #2;
    apply_reset("rst0");

    // Single requester, 4 beats with last on beat 4
    push_pkt(0, 0, 4, 1'b1);
    expect_pkt(0, 0, 4);
    drive();
    tick();
    check("t1_grant_c1", EW'(bus.grants), EW'(3'b001));
    check("t1_rdy_c1",   EW'(bus.rqrdys), EW'(3'b001));
    tick();
    check("t1_wrvld_c2", EW'(bus.wrvld),  EW'(1));
    check("t1_addr_c2",  EW'(bus.wraddr), EW'(32'h5001_0000));
    tick(); tick(); tick();
    check("t1_addr_c5",  EW'(bus.wraddr), EW'(32'h5001_000C));
    check("t1_wrvld_c5", EW'(bus.wrvld),  EW'(1));
    check("t1_grant_c5", EW'(bus.grants), EW'(0));
    check("t1_ptr",      EW'(dbg_ptr),    EW'(1));
    run_until_idle("t1_drain");

    // Three simultaneous 2-beat packets from ptr=0
    apply_reset("rst1");
    for (int r = 0; r < B_RQS; r++) begin
      push_pkt(r, 0, 2, 1'b1);
      expect_pkt(r, 0, 2);
    end
    drive();
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("t2_grant_c%0d", k + 1), EW'(bus.grants), EW'(t2_g[k]));
    end
    check("t2_ptr", EW'(dbg_ptr), EW'(0));
    run_until_idle("t2_drain");

    // Requester 1 streams 12 beats without last; cap at 8 lets requester 2 in
    push_pkt(1, 0, 12, 1'b0);
    push_pkt(2, 0, 2, 1'b1);
    expect_pkt(1, 0, 8);
    expect_pkt(2, 0, 2);
    expect_pkt(1, 8, 4);
    drive();
    for (int k = 0; k < 13; k++) begin
      tick();
      check($sformatf("t3_grant_c%0d", k + 1), EW'(bus.grants), EW'(t3_g[k]));
      if (k == 8) check("t3_ptr_c9", EW'(dbg_ptr), EW'(2));
    end
    run_until_idle("t3_drain");

    // Backpressure: wrrdy low for 5 cycles mid-packet
    push_pkt(2, 0, 4, 1'b1);
    expect_pkt(2, 0, 4);
    drive();
    tick();
    check("t4_grant_c1", EW'(bus.grants), EW'(3'b100));
    tick();
    check("t4_wrvld_c2", EW'(bus.wrvld), EW'(1));
    bus.wrrdy = 1'b0;
    #1;
    check("t4_rdy_bp_c2", EW'(bus.rqrdys), EW'(0));
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t4_wrvld_c%0d", k + 3), EW'(bus.wrvld), EW'(1));
      check($sformatf("t4_hold_c%0d", k + 3), {bus.wraddr, bus.wrdata}, {beat_addr(2, 0), beat_data(2, 0)});
      check($sformatf("t4_rdy_c%0d", k + 3), EW'(bus.rqrdys), EW'(0));
      check($sformatf("t4_grant_c%0d", k + 3), EW'(bus.grants), EW'(3'b100));
    end
    bus.wrrdy = 1'b1;
    #1;
    run_until_idle("t4_drain");

    // Idle timeout: requester 0 goes silent after 2 beats, requester 1 pending
    push_pkt(0, 0, 2, 1'b0);
    push_pkt(1, 0, 1, 1'b1);
    expect_pkt(0, 0, 2);
    expect_pkt(1, 0, 1);
    drive();
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1)  check("t5_grant_c1",  EW'(bus.grants), EW'(3'b001));
      if (k == 18) check("t5_grant_c18", EW'(bus.grants), EW'(3'b001));
      if (k == 19) check("t5_grant_c19", EW'(bus.grants), EW'(3'b000));
      if (k == 19) check("t5_ptr_c19",   EW'(dbg_ptr),    EW'(1));
      if (k == 20) check("t5_grant_c20", EW'(bus.grants), EW'(3'b010));
    end
    run_until_idle("t5_drain");

    // Reset mid-burst, then arbitration restarts from ptr=0
    push_pkt(1, 0, 6, 1'b1);
    expect_pkt(1, 0, 6);
    drive();
    tick();
    check("t6_grant_c1", EW'(bus.grants), EW'(3'b010));
    tick(); tick();
    check("t6_wrvld_c3", EW'(bus.wrvld), EW'(1));
    apply_reset("t6_rst");
    push_pkt(1, 0, 2, 1'b1);
    push_pkt(2, 0, 2, 1'b1);
    expect_pkt(1, 0, 2);
    expect_pkt(2, 0, 2);
    drive();
    tick();
    check("t6_restart_grant", EW'(bus.grants), EW'(3'b010));
    run_until_idle("t6_drain");

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/powlib_busarb.md
Name: powlib_busarb

Overview:
- Round-robin arbiter that shares one powlib bus write port among B_RQS requesters.
- Typical use: merging several masters, such as an IPSAXI bridge and local sequencers, onto a single crossbar write interface.
- A grant is held for a whole packet. A packet ends on a beat marked last, at a beat cap, or after an idle timeout.
- Output is registered, with a standard valid/ready handshake.

Parameters:
- B_RQS, 3, number of requesters (≥2).
- B_AW, 32, bus address width.
- B_DW, 40, packed word width: data, byte enables and op.
- MAX_BEATS, 8, maximum beats per grant before forced re-arbitration (≥1).
- IDLE_MAX, 16, consecutive cycles with the granted requester's vld low before the grant is released (≥1).

Ports:
- clk, input, 1, bus clock.
- rst, input, 1, asynchronous active-low reset.
- rqaddrs, input, B_AW*B_RQS, requester addresses; requester i occupies [B_AW*i+:B_AW].
- rqdatas, input, B_DW*B_RQS, requester packed words.
- rqlasts, input, B_RQS, per-requester last-beat-of-packet flag.
- rqvlds, input, B_RQS, per-requester valid.
- rqrdys, output, B_RQS, per-requester ready.
- wraddr, output, B_AW, arbitrated address.
- wrdata, output, B_DW, arbitrated packed word.
- wrvld, output, 1, output valid.
- wrrdy, input, 1, downstream ready.
- grants, output, B_RQS, one-hot current grant (all zero when idle).

Behaviour:
- Reset (rst=0, asynchronous), values held until rst=1:
  - wrvld=0; wraddr=0; wrdata=0.
  - grants=0; rqrdys=0.
  - Round-robin pointer ptr=0; beat count bcnt=0; idle count icnt=0; state=IDLE.
- Handshakes:
  - A beat transfers on the rising clk edge when vld and rdy are both high.
  - Data, addr and last must be held stable by the sender while vld is high and rdy is low.
- Output register:
  - accept = ~wrvld | wrrdy.
  - On an input beat: wraddr/wrdata are loaded and wrvld=1.
  - Else if wrrdy is high: wrvld=0.
  - A simultaneous drain and load keeps wrvld=1 with the new word.
- State IDLE:
  - rqrdys=0.
  - If any rqvlds bit is set, select the first set index scanning ptr, ptr+1, …, wrapping modulo B_RQS.
  - Next cycle: grants=onehot(sel), bcnt=0, icnt=0, state=GRANT.
  - If no rqvlds bit is set, stay in IDLE.
- State GRANT (granted index g):
  - rqrdys[g]=accept; all other rqrdys=0. This is combinational from wrvld/wrrdy.
  - On a transfer from g: bcnt+1, icnt=0.
  - If rqlasts[g]=1 or bcnt==MAX_BEATS-1 on that transfer: next state IDLE, grants=0, ptr=(g+1) mod B_RQS.
  - If rqvlds[g]=0: icnt+1; when icnt reaches IDLE_MAX-1, next state IDLE, grants=0, ptr=(g+1) mod B_RQS, no beat lost.
  - If rqvlds[g]=1 but accept=0 (backpressure): icnt holds and the grant holds indefinitely.
- Latency:
  - Request seen in IDLE at cycle 0; grant at cycle 1.
  - First beat may transfer at the cycle-1 edge; wrvld=1 in cycle 2.
  - Inside a grant: 1 beat/cycle with wrrdy=1.
  - At least one IDLE cycle between grants.
- Boundaries:
  - Non-granted requesters never see rdy=1.
  - Requests arriving during GRANT wait for IDLE.
  - ptr wraps from B_RQS-1 to 0.
  - MAX_BEATS=1 gives one beat per grant.
  - The output register drains during IDLE regardless of state.
  - A reset mid-packet discards the output register contents and the grant; the requester must resend.
- Counter widths: bcnt is clog2(MAX_BEATS+1) bits; icnt is clog2(IDLE_MAX+1) bits; ptr is clog2(B_RQS) bits.
- Fixed-width arithmetic: no counter wraps within its legal range.

Test Plan:
- Single requester, 4 beats, last on beat 4, wrrdy=1:
  - grants=001 at cycle 1.
  - wrvld high cycles 2–5 with addrs 0x50010000..0x5001000C in order.
  - Return to IDLE; ptr=1.
- Requesters 0, 1 and 2 each send 2-beat packets at once, starting from ptr=0:
  - Grant order is 0, 1, 2, with one IDLE cycle between grants.
  - Output shows 6 beats, never interleaved.
- Requester 1 streams 12 beats with no last, MAX_BEATS=8:
  - Grant released after 8 beats.
  - With requester 2 waiting, requester 2 is granted next.
  - Requester 1 resumes afterwards, with remaining beats intact.
- Backpressure: wrrdy=0 for 5 cycles mid-packet:
  - wrvld stays 1 and wraddr/wrdata stay stable; rqrdys[g]=0.
  - No beat is lost or duplicated when wrrdy returns.
- Idle timeout: granted requester drops vld after 2 beats:
  - Grant released after IDLE_MAX=16 idle cycles.
  - A pending requester is then granted.
- Reset asserted mid-burst at beat 3:
  - Outputs zero asynchronously (wrvld=0, grants=0).
  - After release, arbitration restarts at ptr=0.
